// File: rtl/fft_frame_sink.sv
// -----------------------------------------------------------------------------
// fft_frame_sink
//
// Receive side of the streaming FFT output interface. Each frame of N words
// arrives two words per cycle (o0 = word 2k, o1 = word 2k+1) over N/2
// consecutive beats, the first beat flagged by next_out. Frames are captured
// into one of two banks and replayed one word per transfer on a valid/ready
// read port, oldest frame first.
//
// Ports:
//   clk         clock, everything on the rising edge
//   rst         asynchronous active-low reset (0 = reset)
//   next_out    frame-start strobe, coincident with beat 0
//   o0, o1      even / odd word of the current beat
//   rd_valid    rd_data holds a valid word
//   rd_ready    consumer accepts the current word
//   rd_data     current word (0 when rd_valid = 0)
//   rd_index    index of rd_data within its frame
//   rd_last     high while rd_index = N-1
//   frames_done count of completely captured frames (wraps)
//   overflow    sticky: a frame was dropped because no bank was free
//   proto_err   sticky: next_out arrived in the middle of a frame
//   clr_flags   synchronous clear of both sticky flags (a same-cycle set wins)
//
// N must be a power of two and at least 4.
// -----------------------------------------------------------------------------
module fft_frame_sink #(
  parameter int WIDTH = 64,
  parameter int N     = 32,
  parameter int CNTW  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 next_out,
  input  logic [WIDTH-1:0]     o0,
  input  logic [WIDTH-1:0]     o1,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [WIDTH-1:0]     rd_data,
  output logic [$clog2(N)-1:0] rd_index,
  output logic                 rd_last,
  output logic [CNTW-1:0]      frames_done,
  output logic                 overflow,
  output logic                 proto_err,
  input  logic                 clr_flags
);

  localparam int IW    = $clog2(N);   // word index width
  localparam int BEATS = N / 2;       // beats per frame
  localparam int BW    = IW - 1;      // beat counter width
  localparam int AW    = BW + 1;      // {bank, beat} address into lane memories

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DROP
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d;
  logic [IW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   frames_done_q, frames_done_d;
  logic              overflow_q, overflow_d;
  logic              proto_err_q, proto_err_d;

  // Two word lanes (even / odd), each holding both banks: address = {bank, beat}.
  logic [WIDTH-1:0]  even_mem [N];
  logic [WIDTH-1:0]  odd_mem  [N];

  logic              wr_en;
  logic [BW-1:0]     wr_beat;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     rd_addr;
  logic [WIDTH-1:0]  rd_word;
  logic              rd_valid_w;
  logic              rd_last_w;
  logic              xfer;
  logic              bank_free;
  logic              last_beat;

  // Free/drop decision looks only at the registered full flags, so a bank
  // released by the reader in this very cycle is still treated as occupied.
  assign bank_free  = !full_q[wr_bank_q];
  assign last_beat  = (cnt_q == BW'(BEATS - 1));
  assign rd_valid_w = full_q[rd_bank_q];
  assign rd_last_w  = (rd_ptr_q == IW'(N - 1));
  assign xfer       = rd_valid_w && rd_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    full_d        = full_q;
    rd_ptr_d      = rd_ptr_q;
    frames_done_d = frames_done_q;
    overflow_d    = overflow_q;
    proto_err_d   = proto_err_q;
    wr_en         = 1'b0;
    wr_beat       = cnt_q;

    // Clear first so that any set below in the same cycle takes priority.
    if (clr_flags) begin
      overflow_d  = 1'b0;
      proto_err_d = 1'b0;
    end

    if (next_out) begin
      // A strobe always starts a new frame at beat 0; a partial frame in
      // progress is abandoned and its bank is simply left not-full.
      wr_beat = '0;
      cnt_d   = BW'(1);
      if (state_q != S_IDLE) begin
        proto_err_d = 1'b1;
      end
      if (bank_free) begin
        wr_en   = 1'b1;
        state_d = S_FILL;
      end else begin
        overflow_d = 1'b1;
        state_d    = S_DROP;
      end
    end else begin
      case (state_q)
        S_FILL: begin
          wr_en = 1'b1;
          if (last_beat) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
            frames_done_d     = frames_done_q + CNTW'(1);
            cnt_d             = '0;
            state_d           = S_IDLE;
          end else begin
            cnt_d = cnt_q + BW'(1);
          end
        end
        S_DROP: begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + BW'(1);
          end
        end
        default: ;
      endcase
    end

    // The bank being filled is never full and the bank being read always is,
    // so a release here never collides with the set above.
    if (xfer) begin
      if (rd_last_w) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
        rd_ptr_d          = '0;
      end else begin
        rd_ptr_d = rd_ptr_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      full_q        <= '0;
      rd_ptr_q      <= '0;
      frames_done_q <= '0;
      overflow_q    <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      full_q        <= full_d;
      rd_ptr_q      <= rd_ptr_d;
      frames_done_q <= frames_done_d;
      overflow_q    <= overflow_d;
      proto_err_q   <= proto_err_d;
    end
  end

  // Frame storage: contents need no reset, validity lives in full_q.
  assign wr_addr = {wr_bank_q, wr_beat};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      even_mem[wr_addr] <= o0;
      odd_mem[wr_addr]  <= o1;
    end
  end

  // Word w of a frame sits in lane w[0] at beat w>>1.
  assign rd_addr = {rd_bank_q, rd_ptr_q[IW-1:1]};
  assign rd_word = rd_ptr_q[0] ? odd_mem[rd_addr] : even_mem[rd_addr];

  assign rd_valid    = rd_valid_w;
  assign rd_data     = rd_valid_w ? rd_word : '0;
  assign rd_index    = rd_ptr_q;
  assign rd_last     = rd_last_w;
  assign frames_done = frames_done_q;
  assign overflow    = overflow_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_fft_frame_sink.sv
module tb_fft_frame_sink;

  localparam int W  = 64;
  localparam int N  = 32;
  localparam int CW = 3;   // narrow counter so wrap-around is reached quickly

  logic          clk = 1'b0;
  logic          rst;
  logic          next_out;
  logic [W-1:0]  o0, o1;
  logic          rd_valid;
  logic          rd_ready;
  logic [W-1:0]  rd_data;
  logic [4:0]    rd_index;
  logic          rd_last;
  logic [CW-1:0] frames_done;
  logic          overflow;
  logic          proto_err;
  logic          clr_flags;

  always #5 clk = ~clk;

  fft_frame_sink #(.WIDTH(W), .N(N), .CNTW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .next_out   (next_out),
    .o0         (o0),
    .o1         (o1),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_index   (rd_index),
    .rd_last    (rd_last),
    .frames_done(frames_done),
    .overflow   (overflow),
    .proto_err  (proto_err),
    .clr_flags  (clr_flags)
  );

  typedef struct {
    logic         ready;
    logic         exp_valid;
    logic [W-1:0] exp_data;
    logic [4:0]   exp_index;
    logic         exp_last;
  } vec_t;

  vec_t         vecs [35];
  int           tests = 0;
  int           fails = 0;
  int           exp_frames;
  int           rd_count;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] fbuf [N];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] base);
    for (int i = 0; i < N; i++) fbuf[i] = base + W'(i);
  endtask

  // Drive beats first..first+nb-1 of fbuf; next_out accompanies beat 0.
  task automatic send_beats(input int first, input int nb);
    for (int b = first; b < first + nb; b++) begin
      next_out = (b == 0);
      o0 = fbuf[2*b];
      o1 = fbuf[2*b+1];
      tick();
    end
    next_out = 1'b0;
    o0 = '0;
    o1 = '0;
  endtask

  task automatic expect_frame();
    for (int i = 0; i < N; i++) exp_q.push_back(fbuf[i]);
    exp_frames++;
    $display("[TB] frame base=%0d sent, expected captured", fbuf[0]);
  endtask

  task automatic check_frames(input string name);
    check(name, W'(frames_done), W'(exp_frames % (1 << CW)));
  endtask

  // Compare the word currently offered against the oldest expected word.
  task automatic check_word();
    logic [W-1:0] e;
    int           idx;
    e   = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    idx = rd_count % N;
    check("rd_valid", W'(rd_valid), 1);
    check("rd_data", rd_data, e);
    check("rd_index", W'(rd_index), W'(idx));
    check("rd_last", W'(rd_last), W'(idx == N - 1));
    $display("[TB] read idx=%0d data=%0d", rd_index, rd_data);
    rd_count++;
  endtask

  task automatic read_words(input int n);
    for (int k = 0; k < n; k++) begin
      rd_ready = 1'b1;
      check_word();
      tick();
    end
    rd_ready = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rd_valid"}, W'(rd_valid), 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_rd_index"}, W'(rd_index), 0);
    check({tag, "_rd_last"}, W'(rd_last), 0);
    check({tag, "_frames_done"}, W'(frames_done), 0);
    check({tag, "_overflow"}, W'(overflow), 0);
    check({tag, "_proto_err"}, W'(proto_err), 0);
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    next_out  = 1'b0;
    o0        = '0;
    o1        = '0;
    rd_ready  = 1'b0;
    clr_flags = 1'b0;
    repeat (2) tick();
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    tick();
    exp_q.delete();
    exp_frames = 0;
    rd_count   = 0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  initial begin
    // Readout table for frame 0: two stall cycles, 32 transfers, then empty.
    for (int i = 0; i < 35; i++) begin
      if (i < 2) begin
        vecs[i] = '{ready: 1'b0, exp_valid: 1'b1, exp_data: '0, exp_index: 5'd0, exp_last: 1'b0};
      end else if (i < 34) begin
        vecs[i] = '{ready: 1'b1, exp_valid: 1'b1, exp_data: W'(i - 2),
                    exp_index: 5'(i - 2), exp_last: (i == 33)};
      end else begin
        vecs[i] = '{ready: 1'b0, exp_valid: 1'b0, exp_data: '0, exp_index: 5'd0, exp_last: 1'b0};
      end
    end

    // ---- Frame 0 and its readout ------------------------------------------
    do_reset();
    load(0);
    send_beats(0, 15);
    check("t1_valid_before_last_beat", W'(rd_valid), 0);
    send_beats(15, 1);
    exp_frames = 1;
    check_frames("t1_frames_done");
    for (int i = 0; i < 35; i++) begin
      rd_ready = vecs[i].ready;
      check("t1_vec_valid", W'(rd_valid), W'(vecs[i].exp_valid));
      check("t1_vec_data", rd_data, vecs[i].exp_data);
      check("t1_vec_index", W'(rd_index), W'(vecs[i].exp_index));
      check("t1_vec_last", W'(rd_last), W'(vecs[i].exp_last));
      $display("[TB] vec %0d ready=%0d valid=%0d data=%0d idx=%0d last=%0d",
               i, vecs[i].ready, rd_valid, rd_data, rd_index, rd_last);
      tick();
    end
    rd_ready = 1'b0;

    // ---- Two back-to-back frames held, then read in order -------------------
    do_reset();
    load(496);
    fbuf[1] = 64'd700079669232;
    send_beats(0, 16);
    expect_frame();
    load(1520);
    send_beats(0, 16);
    expect_frame();
    check_frames("t2_frames_done");
    repeat (3) tick();
    check("t2_hold_valid", W'(rd_valid), 1);
    check("t2_hold_data", rd_data, 496);
    read_words(64);
    check("t2_empty_after_read", W'(rd_valid), 0);
    check("t2_overflow", W'(overflow), 0);

    // ---- Overrun: third frame with both banks full --------------------------
    load(3000);
    send_beats(0, 16);
    expect_frame();
    load(4000);
    send_beats(0, 16);
    expect_frame();
    load(5000);
    send_beats(0, 1);
    check("t3_overflow_set", W'(overflow), 1);
    send_beats(1, 15);
    check_frames("t3_frames_unchanged");
    read_words(64);
    check("t3_dropped_not_stored", W'(rd_valid), 0);

    // ---- Release in the same cycle as a new frame start ---------------------
    pulse_clr();
    check("t4_overflow_cleared", W'(overflow), 0);
    load(6000);
    send_beats(0, 16);
    expect_frame();
    load(7000);
    send_beats(0, 16);
    expect_frame();
    read_words(31);
    check("t4_at_last_word", W'(rd_last), 1);
    load(8000);
    next_out = 1'b1;
    o0       = fbuf[0];
    o1       = fbuf[1];
    rd_ready = 1'b1;
    check_word();
    tick();
    rd_ready = 1'b0;
    next_out = 1'b0;
    check("t4_overflow_on_release_race", W'(overflow), 1);
    send_beats(1, 15);
    check_frames("t4_frames_unchanged");
    read_words(32);
    check("t4_dropped_not_stored", W'(rd_valid), 0);

    // ---- Protocol error: strobe at beat 7 -----------------------------------
    pulse_clr();
    check("t5_overflow_cleared", W'(overflow), 0);
    check("t5_proto_clear_before", W'(proto_err), 0);
    load(9000);
    send_beats(0, 7);
    load(10000);
    send_beats(0, 16);
    expect_frame();
    check("t5_proto_err_set", W'(proto_err), 1);
    check("t5_no_overflow", W'(overflow), 0);
    check_frames("t5_frames_done");
    read_words(32);
    check("t5_partial_discarded", W'(rd_valid), 0);
    pulse_clr();
    check("t5_proto_err_cleared", W'(proto_err), 0);
    // Clear and a new mid-frame strobe in the same cycle: the set wins.
    load(11000);
    send_beats(0, 3);
    clr_flags = 1'b1;
    load(12000);
    send_beats(0, 1);
    clr_flags = 1'b0;
    check("t5_set_wins_over_clear", W'(proto_err), 1);
    send_beats(1, 15);
    expect_frame();
    check_frames("t5_frames_done_wrap");
    read_words(32);
    pulse_clr();
    check("t5_proto_err_cleared2", W'(proto_err), 0);

    // ---- Asynchronous reset mid-operation -----------------------------------
    load(13000);
    send_beats(0, 16);
    expect_frame();
    read_words(5);
    load(14000);
    send_beats(0, 5);
    check("t6_read_in_progress", W'(rd_index), 5);
    #2;
    rst = 1'b0;
    #1;
    check_zero_outputs("t6_async");
    do_reset();
    load(15000);
    send_beats(0, 16);
    expect_frame();
    check_frames("t6_frames_after_reset");
    read_words(32);
    check("t6_empty_after_read", W'(rd_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
